fifo_write_logic: RTL
=====================

# fifo_write_logic

Write-domain pointer and flag controller for the team's asynchronous FIFO. It sits directly upstream of the read-side controller. It accepts write requests from the producer and drives the dual-port memory write enable and address. It publishes a Gray-coded write pointer, which the read domain synchronizes for empty detection. It also derives full, almost-full and sticky overflow flags from the read pointer after that pointer has been synchronized into the write clock domain.

## Interface
- PTR_SZ, 2, address width. FIFO depth = 2^PTR_SZ. Legal range PTR_SZ >= 2.
- AFULL_THRESH, 3, occupancy at or above which walmost_full asserts. Legal range 1..2^PTR_SZ.

- clk  in  1  write-domain clock. All state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- winc  in  1  producer write request, sampled on the rising edge of clk.
- wq2_raddr  in  PTR_SZ+1  Gray read pointer, already double-flop synchronized into clk.
- wovf_clr  in  1  synchronous clear of wovf.
- write_en  out  1  memory write strobe, combinational.
- waddr  out  PTR_SZ  memory write address, registered.
- waddr_gray  out  PTR_SZ+1  Gray write pointer to the read domain, registered, glitch-free.
- wfull  out  1  FIFO full, registered.
- walmost_full  out  1  occupancy >= AFULL_THRESH, registered.
- wovf  out  1  sticky overflow: a write was attempted while full.
- wstate  out  2  FSM state, for debug and status.

## Operation
- Internal binary pointer wbin[PTR_SZ:0]. waddr = wbin[PTR_SZ-1:0]. waddr_gray = (wbin>>1)^wbin, both held in registers.
- accept = winc & ~wfull. write_en = accept. The memory writes at the current waddr on the same edge.
- wbin_next = wbin + accept, computed modulo 2^(PTR_SZ+1). wgray_next = (wbin_next>>1)^wbin_next.
- wfull_next = (wgray_next == {~wq2_raddr[PTR_SZ:PTR_SZ-1], wq2_raddr[PTR_SZ-2:0]}).
- rbin = Gray-to-binary of wq2_raddr, computed as a prefix XOR from the MSB.
- count_next = (wbin_next - rbin) mod 2^(PTR_SZ+1). Range 0..2^PTR_SZ.
- walmost_full_next = (count_next >= AFULL_THRESH).
- wovf: set when winc & wfull. Cleared when wovf_clr=1 and no set condition occurs in that cycle. If set and clear occur together, set wins.
- FSM states and transitions (evaluated on next-cycle values):
  - IDLE=00: entered when count_next == 0.
  - ACTIVE=01: entered when 0 < count_next and wfull_next=0.
  - FULL=10: entered when wfull_next=1.
  - Any state can move to any state in one cycle.
  - Encoding 11 is unreachable. If it occurs, the FSM recovers to IDLE on the next edge.
- wstate equals the FSM state register. wfull equals (state == FULL).
- Overflow write (winc while wfull): write_en=0 and wbin is unchanged. The producer must retry the write.
- Wrap-around: wbin rolls over from 2^(PTR_SZ+1)-1 to 0 with no special handling. The full and count arithmetic is modular.

## Timing
- Reset (rst=0, asynchronous): write_en depends only on inputs and wfull, so while wfull=0 it follows winc. All registered outputs clear immediately:
  - waddr = 0, waddr_gray = 0
  - wfull = 0, walmost_full = 0 (requires AFULL_THRESH >= 1)
  - wovf = 0, wstate = IDLE
- Reset asserted mid-operation discards pointer state immediately. The read domain must be reset together with this block.
- Latency:
  - An accepted write advances waddr and waddr_gray on the same edge.
  - wfull and walmost_full reflect that write on the same edge.
  - A winc in the following cycle sees the updated wfull.
- Read frees become visible only after wq2_raddr changes. wq2_raddr lags the read domain by 2 clk cycles plus the read-clock skew.
  - wfull therefore deasserts pessimistically; it is never late in asserting.
  - wfull clears on the first edge after wq2_raddr advances.
- waddr_gray changes by at most one bit per cycle.

## Test plan
1. Assert rst low mid-cycle with winc=1 -> all registered outputs go to 0 / IDLE immediately, without a clock edge. After release, the first edge with winc=1 writes to waddr=0.
2. PTR_SZ=2, AFULL_THRESH=3, wq2_raddr=000, winc=1 for 4 cycles:
   - write_en=1 with waddr 0,1,2,3.
   - waddr_gray goes 001, 011, 010, 110.
   - walmost_full rises after the 3rd write.
   - wfull rises and wstate=FULL after the 4th write.
3. Continue from 2 with a 5th winc -> write_en=0, waddr_gray stays 110, wovf=1 on the next edge. wovf holds until a wovf_clr pulse clears it on the following edge. When winc and wovf_clr are applied together while full, wovf stays 1.
4. Continue from 2 and drive wq2_raddr=001:
   - Next edge: wfull=0, walmost_full=1, wstate=ACTIVE.
   - One winc then gives waddr_gray=111 and wfull=1 again.
5. Wrap test: keep wq2_raddr one entry behind the writer over 20 writes -> wbin wraps 111 to 000 (waddr_gray 100 to 000). There is no false wfull, no wovf, and waddr cycles 0..3.
6. Drain to empty: set wq2_raddr equal to waddr_gray with winc=0 -> next edge: wstate=IDLE, walmost_full=0, wfull=0.

Source files
------------

// File: rtl/fifo_write_logic.sv
// fifo_write_logic: write-domain pointer, full/almost-full/overflow flags for the async FIFO
// Ports:
//   clk, rst          write clock, asynchronous active-low reset
//   winc              producer write request
//   wq2_raddr         Gray read pointer already synchronized into clk
//   wovf_clr          synchronous clear of the sticky overflow flag
//   write_en          memory write strobe (combinational)
//   waddr             memory write address
//   waddr_gray        Gray write pointer published to the read domain
//   wfull             FIFO full
//   walmost_full      occupancy >= AFULL_THRESH
//   wovf              sticky overflow (write attempted while full)
//   wstate            FSM state: 00 IDLE, 01 ACTIVE, 10 FULL
module fifo_write_logic #(
    parameter int PTR_SZ       = 2,
    parameter int AFULL_THRESH = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              winc,
    input  logic [PTR_SZ:0]   wq2_raddr,
    input  logic              wovf_clr,
    output logic              write_en,
    output logic [PTR_SZ-1:0] waddr,
    output logic [PTR_SZ:0]   waddr_gray,
    output logic              wfull,
    output logic              walmost_full,
    output logic              wovf,
    output logic [1:0]        wstate
);
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] ACTIVE = 2'b01;
    localparam logic [1:0] FULL   = 2'b10;
    localparam logic [PTR_SZ:0] THRESH = AFULL_THRESH[PTR_SZ:0];

    logic [PTR_SZ:0] wbin_q, wbin_d, wgray_q, wgray_d, rbin, count_d;
    logic [1:0]      state_q, state_d;
    logic            afull_q, afull_d, wovf_q, wovf_d, wfull_d, accept;

    assign wfull        = state_q == FULL;
    assign accept       = winc & ~wfull;
    assign write_en     = accept;
    assign waddr        = wbin_q[PTR_SZ-1:0];
    assign waddr_gray   = wgray_q;
    assign walmost_full = afull_q;
    assign wovf         = wovf_q;
    assign wstate       = state_q;

    // Read pointer back to binary: each bit is the XOR of all Gray bits above and including it
    always_comb begin
        rbin[PTR_SZ] = wq2_raddr[PTR_SZ];
        for (int i = PTR_SZ - 1; i >= 0; i--) rbin[i] = rbin[i+1] ^ wq2_raddr[i];
    end

    always_comb begin
        wbin_d  = wbin_q + {{PTR_SZ{1'b0}}, accept};
        wgray_d = (wbin_d >> 1) ^ wbin_d;
        // Full when the writer is one lap ahead: top two Gray bits inverted, rest equal
        wfull_d = wgray_d == {~wq2_raddr[PTR_SZ:PTR_SZ-1], wq2_raddr[PTR_SZ-2:0]};
        count_d = wbin_d - rbin;
        afull_d = count_d >= THRESH;
        wovf_d  = (winc & wfull) | (wovf_q & ~wovf_clr);
        // The illegal 11 encoding is flushed to IDLE before normal decoding resumes
        state_d = state_q == 2'b11 ? IDLE :
                  wfull_d          ? FULL :
                  count_d == '0    ? IDLE : ACTIVE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            state_q <= IDLE;
            afull_q <= 1'b0;
            wovf_q  <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            state_q <= state_d;
            afull_q <= afull_d;
            wovf_q  <= wovf_d;
        end
    end
endmodule
